serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//   Bit-serial adder controller. Time-shares one instance of the team's
//   fulladder cell (ports sum, c_out, a, b, c_in) to add two WIDTH-bit operands,
//   one bit per clock, LSB first. A start/busy/done handshake sequences each
//   operation. Used where area matters more than latency.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 1..32
// PORTS
//   clk      in   1      single clock; all state updates on rising edge
//   rst      in   1      synchronous reset, active-high
//   start    in   1      request an add; sampled only when accepted (see below)
//   a_in     in   WIDTH  operand A, captured on the accepting edge
//   b_in     in   WIDTH  operand B, captured on the accepting edge
//   c_in     in   1      carry-in, captured on the accepting edge
//   busy     out  1      1 while in RUN
//   done     out  1      single-cycle pulse when the result is valid
//   sum_out  out  WIDTH  result sum; holds until the next completion
//   c_out    out  1      final carry-out; holds with sum_out
// BEHAVIOUR
//   - Reset: sync, active-high. Reset dominates all other inputs.
//     State=IDLE; busy=0, done=0, sum_out=0, c_out=0.
//     Internal operand shift regs, carry flop and bit counter are cleared.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE: start=1 -> capture a_in/b_in/c_in, set counter=0, go to RUN.
//     RUN: each edge feeds a_sh[0], b_sh[0] and carry into fulladder.
//       The sum bit shifts into the MSB of the result shift reg.
//       The carry flop takes fulladder c_out.
//       a_sh/b_sh shift right by 1; counter increments.
//       After the edge that processes bit WIDTH-1, go to DONE.
//       sum_out/c_out load the final result on that same edge.
//     DONE: done=1 for exactly this cycle.
//       start=1 -> accept a new op, as in IDLE (back-to-back); else go to IDLE.
//   - Latency: start accepted at edge E0; done=1 in the cycle after edge E0+WIDTH.
//     That is WIDTH clocks in RUN, then one DONE cycle.
//     Throughput: one op per WIDTH+1 clocks.
//   - start during RUN: ignored. The op in flight and the captured operands are
//     unaffected, and the request is not queued.
//   - a_in/b_in/c_in are don't-care except on the accepting edge.
//   - Widths: result = (a + b + c_in) mod 2^WIDTH; c_out = bit WIDTH of the full sum.
//     Counter width is $clog2(WIDTH+1).
//   - sum_out/c_out update only on entry to DONE. They are stable in every other
//     state, including RUN.
//   - rst mid-RUN: aborts the op; no done pulse; outputs return to 0.
//   - WIDTH=1: RUN lasts exactly one cycle. The result equals one fulladder eval.
// TESTING  (WIDTH=8 unless stated)
//   1. Reset: rst=1 for 2 clk -> busy=0, done=0, sum_out=8'h00, c_out=0.
//   2. a=8'hFF, b=8'h01, c_in=0, start pulse -> busy=1 for 8 clk, then
//      done=1 for 1 clk; sum_out=8'h00, c_out=1.
//   3. a=8'h5A, b=8'h33, c_in=1 -> sum_out=8'h8E, c_out=0.
//      Pulse start=1 with a=8'h00 mid-RUN -> result unchanged; one done only.
//   4. Hold start=1 continuously, changing operands each op -> done pulses every
//      9 clk. Each result matches the operands present on its accepting edge.
//   5. rst=1 at RUN cycle 4 of a=8'hAA, b=8'h55 -> no done pulse; IDLE next cycle;
//      outputs 0. A later op completes correctly.
//   6. WIDTH=1: all 8 {a,b,c_in} combos -> {c_out,sum_out} matches the
//      full-adder truth table. done fires 1 clk after busy.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one fulladder cell reused over WIDTH clocks, LSB first,
// sequenced by a start/busy/done handshake.

module fulladder (
   output logic sum,
   output logic c_out,
   input  logic a,
   input  logic b,
   input  logic c_in
);
   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             c_out
);
   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] r_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_sum;
   logic             fa_co;
   logic             accept;

   fulladder u_fa (
      .sum   (fa_sum),
      .c_out (fa_co),
      .a     (a_sh[0]),
      .b     (b_sh[0]),
      .c_in  (carry)
   );

   // New sum bit enters at the MSB so the result is aligned after WIDTH shifts.
   always_comb begin
      r_next            = r_sh >> 1;
      r_next[WIDTH-1]   = fa_sum;
   end

   assign accept = start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         r_sh    <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum_out <= '0;
         c_out   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= c_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
         end else begin
            case (state)
               RUN: begin
                  a_sh  <= a_sh >> 1;
                  b_sh  <= b_sh >> 1;
                  r_sh  <= r_next;
                  carry <= fa_co;
                  cnt   <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state   <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     sum_out <= r_next;
                     c_out   <= fa_co;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
